// File: rtl/bus_resp_ctrl.sv
// -----------------------------------------------------------------------------
// bus_resp_ctrl
//
// Return-side bus response controller for the 65C02 bus. It latches the
// decoder chip selects and the read/write direction at cycle start. It stalls
// the CPU through RDY until the selected device acks. It then registers the
// read data and holds it on the CPU data bus until the cycle ends. Open-bus
// reads, multiple selects and (optionally) device timeouts all return
// OPEN_BUS_VAL.
//
// Build option:
//   BUS_RESP_TIMEOUT_EN  defined   -> WAIT gives up after TIMEOUT_CYCLES clocks
//                                     and raises o_timeout_err.
//                        undefined -> WAIT holds until ack, and o_timeout_err
//                                     is tied to 0.
//
// Ports:
//   i_clk, i_rst_n   clock and asynchronous active-low reset
//   i_cycle_start    one-clk pulse; address, i_rwb and i_cs are valid
//   i_cycle_end      one-clk pulse; the CPU has finished the bus cycle
//   i_rwb            1 = read, 0 = write
//   i_cs             one-hot chip selects (DEV_N slots)
//   i_dev_data       per-slot read data; slot k is at [8k+7:8k]
//   i_dev_ack        per-slot ready (level)
//   i_err_clr        clears the sticky error flags
//   o_cpu_rdy        CPU RDY (0 = stall)
//   o_cpu_data       held read data
//   o_data_oe        drive the CPU data bus
//   o_multi_err      sticky: more than one chip select was seen
//   o_timeout_err    sticky: a device timeout fired
// -----------------------------------------------------------------------------
module bus_resp_ctrl #(
   parameter int          DEV_N          = 8,
   parameter int          TIMEOUT_CYCLES = 255,
   parameter logic [7:0]  OPEN_BUS_VAL   = 8'hFF
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_cycle_start,
   input  logic                 i_cycle_end,
   input  logic                 i_rwb,
   input  logic [DEV_N-1:0]     i_cs,
   input  logic [8*DEV_N-1:0]   i_dev_data,
   input  logic [DEV_N-1:0]     i_dev_ack,
   input  logic                 i_err_clr,
   output logic                 o_cpu_rdy,
   output logic [7:0]           o_cpu_data,
   output logic                 o_data_oe,
   output logic                 o_multi_err,
   output logic                 o_timeout_err
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

   localparam logic [DEV_N-1:0] CS_ONE = DEV_N'(1);

   state_t             state_q, state_d;
   logic               rwb_q, rwb_d;
   logic [DEV_N-1:0]   cs_q, cs_d;
   logic               rdy_q, rdy_d;
   logic [7:0]         data_q, data_d;
   logic               oe_q, oe_d;
   logic               multi_q, multi_set;
   logic               timeout_hit;

   // One-hot select of a slot's data. The result is an AND-OR mux, so a zero
   // select yields 0. The callers never use that value, because a zero select
   // is handled as an open bus.
   function automatic logic [7:0] slot_data(input logic [DEV_N-1:0]   cs,
                                            input logic [8*DEV_N-1:0] data);
      logic [7:0] r;
      r = 8'h00;
      for (int k = 0; k < DEV_N; k++)
         r = r | ({8{cs[k]}} & data[8*k +: 8]);
      return r;
   endfunction

   // Select decode on the live decoder outputs (used at cycle start only).
   logic cs_none, cs_multi, start_ack, wait_ack;
   logic [7:0] start_data, wait_data;

   assign cs_none    = (i_cs == '0);
   assign cs_multi   = ((i_cs & (i_cs - CS_ONE)) != '0);
   assign start_ack  = |(i_cs & i_dev_ack);
   assign wait_ack   = |(cs_q & i_dev_ack);
   assign start_data = slot_data(i_cs, i_dev_data);
   assign wait_data  = slot_data(cs_q, i_dev_data);

   // ---------------------------------------------------------------- timeout
`ifdef BUS_RESP_TIMEOUT_EN
   logic [7:0] tmo_cnt_q;
   logic       tmo_set;
   logic       tmo_err_q;

   // The counter is 0 on the first WAIT clock, so the compare against
   // TIMEOUT_CYCLES-1 releases RDY exactly TIMEOUT_CYCLES clocks after
   // the controller enters WAIT.
   assign timeout_hit = (state_q == S_WAIT) && (tmo_cnt_q == 8'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         tmo_cnt_q <= 8'h00;
      end else if (state_q == S_IDLE) begin
         tmo_cnt_q <= 8'h00;
      end else if (state_q == S_WAIT && tmo_cnt_q != 8'hFF) begin
         tmo_cnt_q <= tmo_cnt_q + 8'h01;
      end
   end

   // A set in the same cycle wins over a clear.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) tmo_err_q <= 1'b0;
      else          tmo_err_q <= tmo_set | (tmo_err_q & ~i_err_clr);
   end

   assign o_timeout_err = tmo_err_q;
`else
   assign timeout_hit   = 1'b0;
   assign o_timeout_err = 1'b0;
`endif

   // ------------------------------------------------------------ state reg
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   // ----------------------------------------------------------- next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: if (i_cycle_start) begin
            if (!cs_none && !cs_multi && !start_ack) state_d = S_WAIT;
            else                                     state_d = S_HOLD;
         end
         S_WAIT: if (wait_ack || timeout_hit) state_d = S_HOLD;
         S_HOLD: if (i_cycle_end)             state_d = S_IDLE;
         default:                             state_d = S_IDLE;
      endcase
   end

   // ------------------------------------------------ next registered outputs
   // Every output is registered. This block computes the value that each
   // output register loads on the next edge.
   always_comb begin
      rwb_d     = rwb_q;
      cs_d      = cs_q;
      rdy_d     = rdy_q;
      data_d    = data_q;
      oe_d      = oe_q;
      multi_set = 1'b0;
`ifdef BUS_RESP_TIMEOUT_EN
      tmo_set   = 1'b0;
`endif
      unique case (state_q)
         S_IDLE: if (i_cycle_start) begin
            rwb_d = i_rwb;
            cs_d  = i_cs;
            if (cs_none || cs_multi) begin
               multi_set = cs_multi;
               if (i_rwb) data_d = OPEN_BUS_VAL;
               oe_d = i_rwb;
            end else if (start_ack) begin
               if (i_rwb) data_d = start_data;
               oe_d = i_rwb;
            end else begin
               rdy_d = 1'b0;
            end
         end
         S_WAIT: begin
            // Ack takes priority over a timeout in the same cycle.
            if (wait_ack) begin
               rdy_d = 1'b1;
               if (rwb_q) data_d = wait_data;
               oe_d  = rwb_q;
            end else if (timeout_hit) begin
               rdy_d = 1'b1;
               if (rwb_q) data_d = OPEN_BUS_VAL;
               oe_d  = rwb_q;
`ifdef BUS_RESP_TIMEOUT_EN
               tmo_set = 1'b1;
`endif
            end
         end
         S_HOLD: if (i_cycle_end) oe_d = 1'b0;
         default: ;
      endcase
   end

   // ------------------------------------------------------- output registers
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rwb_q   <= 1'b1;
         cs_q    <= '0;
         rdy_q   <= 1'b1;
         data_q  <= 8'h00;
         oe_q    <= 1'b0;
         multi_q <= 1'b0;
      end else begin
         rwb_q   <= rwb_d;
         cs_q    <= cs_d;
         rdy_q   <= rdy_d;
         data_q  <= data_d;
         oe_q    <= oe_d;
         multi_q <= multi_set | (multi_q & ~i_err_clr);
      end
   end

   assign o_cpu_rdy   = rdy_q;
   assign o_cpu_data  = data_q;
   assign o_data_oe   = oe_q;
   assign o_multi_err = multi_q;

endmodule

// File: tb/tb_bus_resp_ctrl.sv
// Directed bench for bus_resp_ctrl. The DUT is built with TIMEOUT_CYCLES = 16.
// Expected values follow the macro BUS_RESP_TIMEOUT_EN, so that this bench
// and the RTL are compiled with the same macro setting.
module tb_bus_resp_ctrl;

   localparam int DEV_N = 8;

   logic                clk = 1'b0;
   logic                rst_n;
   logic                cycle_start, cycle_end, rwb, err_clr;
   logic [DEV_N-1:0]    cs, ack;
   logic [8*DEV_N-1:0]  dev_data;
   logic                cpu_rdy, data_oe, multi_err, timeout_err;
   logic [7:0]          cpu_data;

   int n_chk  = 0;
   int n_pass = 0;
   int n;
   logic [7:0] last_data;

   bus_resp_ctrl #(.DEV_N(DEV_N), .TIMEOUT_CYCLES(16), .OPEN_BUS_VAL(8'hFF)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_cycle_start(cycle_start),
      .i_cycle_end(cycle_end), .i_rwb(rwb), .i_cs(cs), .i_dev_data(dev_data),
      .i_dev_ack(ack), .i_err_clr(err_clr), .o_cpu_rdy(cpu_rdy),
      .o_cpu_data(cpu_data), .o_data_oe(data_oe), .o_multi_err(multi_err),
      .o_timeout_err(timeout_err));

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Pulse cycle_start for one clock, then drop the selects as the decoder would.
   task automatic start_cycle(input logic [DEV_N-1:0] sel, input logic rw);
      cs = sel; rwb = rw; cycle_start = 1'b1;
      tick();
      cycle_start = 1'b0; cs = '0; rwb = 1'b1;
   endtask

   task automatic end_cycle();
      cycle_end = 1'b1;
      tick();
      cycle_end = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; cycle_start = 1'b0; cycle_end = 1'b0; rwb = 1'b1;
      err_clr = 1'b0; cs = '0; ack = '0; dev_data = '0;
      #12;
      check("rst_rdy",   cpu_rdy,     1'b1);
      check("rst_data",  cpu_data,    8'h00);
      check("rst_oe",    data_oe,     1'b0);
      check("rst_multi", multi_err,   1'b0);
      check("rst_tmo",   timeout_err, 1'b0);
      tick();
      rst_n = 1'b1;
      tick();

      // ROM read, ack already high: zero-wait.
      dev_data[7:0] = 8'hA9; ack = 8'h01;
      start_cycle(8'h01, 1'b1);
      check("rom_rdy",  cpu_rdy,  1'b1);
      check("rom_data", cpu_data, 8'hA9);
      check("rom_oe",   data_oe,  1'b1);
      // A second start while holding is ignored, even with a multi select.
      start_cycle(8'h03, 1'b1);
      check("hold_ign_multi", multi_err, 1'b0);
      check("hold_ign_data",  cpu_data,  8'hA9);
      check("hold_oe",        data_oe,   1'b1);
      end_cycle();
      check("rom_oe_off",  data_oe,  1'b0);
      check("rom_data_kp", cpu_data, 8'hA9);
      ack = '0;

      // SDRAM read with an ack 5 clocks after the start.
      dev_data[63:56] = 8'h3C;
      start_cycle(8'h80, 1'b1);
      n = 0;
      while (!cpu_rdy && n < 100) begin
         n++;
         if (n == 5) ack[7] = 1'b1;
         tick();
      end
      check("sdram_stall", n, 5);
      check("sdram_data",  cpu_data, 8'h3C);
      check("sdram_oe",    data_oe,  1'b1);
      end_cycle();
      check("sdram_oe_off", data_oe, 1'b0);
      ack = '0;

      // Two selects at once: open bus plus the sticky error flag.
      start_cycle(8'b0010_0001, 1'b1);
      check("multi_flag", multi_err, 1'b1);
      check("multi_data", cpu_data,  8'hFF);
      check("multi_rdy",  cpu_rdy,   1'b1);
      end_cycle();
      err_clr = 1'b1; tick(); err_clr = 1'b0;
      check("multi_clr", multi_err, 1'b0);
      // Set and clear in the same cycle: the set wins.
      err_clr = 1'b1;
      start_cycle(8'h11, 1'b1);
      err_clr = 1'b0;
      check("multi_set_wins", multi_err, 1'b1);
      end_cycle();
      err_clr = 1'b1; tick(); err_clr = 1'b0;
      check("multi_clr2", multi_err, 1'b0);

      // UART slot that does not ack until clock 40 (the timeout fires first
      // when the timeout feature is built in).
      dev_data[47:40] = 8'h5A;
      start_cycle(8'h20, 1'b1);
      n = 0;
      while (!cpu_rdy && n < 100) begin
         n++;
         if (n == 40) ack[5] = 1'b1;
         tick();
      end
`ifdef BUS_RESP_TIMEOUT_EN
      check("uart_stall", n, 16);
      check("uart_data",  cpu_data,    8'hFF);
      check("uart_tmo",   timeout_err, 1'b1);
      last_data = 8'hFF;
`else
      check("uart_stall", n, 40);
      check("uart_data",  cpu_data,    8'h5A);
      check("uart_tmo",   timeout_err, 1'b0);
      last_data = 8'h5A;
`endif
      check("uart_oe", data_oe, 1'b1);
      end_cycle();
      ack = '0;
      err_clr = 1'b1; tick(); err_clr = 1'b0;
      check("tmo_clr", timeout_err, 1'b0);

      // SDRAM write with an ack after 3 clocks: stall, no drive, data kept.
      dev_data[63:56] = 8'h77;
      start_cycle(8'h80, 1'b0);
      check("wr_oe_stall", data_oe, 1'b0);
      n = 0;
      while (!cpu_rdy && n < 100) begin
         n++;
         if (n == 3) ack[7] = 1'b1;
         tick();
      end
      check("wr_stall", n, 3);
      check("wr_oe",    data_oe,  1'b0);
      check("wr_data",  cpu_data, last_data);
      end_cycle();
      ack = '0;

      // Reset in the middle of a WAIT.
      dev_data[55:48] = 8'h42;
      start_cycle(8'h40, 1'b1);
      tick();
      check("mid_wait_rdy", cpu_rdy, 1'b0);
      rst_n = 1'b0;
      #1;
      check("async_rst_rdy",  cpu_rdy,  1'b1);
      check("async_rst_oe",   data_oe,  1'b0);
      check("async_rst_data", cpu_data, 8'h00);
      tick();
      rst_n = 1'b1;
      tick();
      start_cycle(8'h00, 1'b1);
      check("open_rdy",   cpu_rdy,   1'b1);
      check("open_data",  cpu_data,  8'hFF);
      check("open_oe",    data_oe,   1'b1);
      check("open_multi", multi_err, 1'b0);
      end_cycle();
      check("open_oe_off", data_oe, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
